// File: rtl/display_pkg.sv
// display_pkg: shared definitions for logic that drives the four-digit
// segment display slave (frame geometry, slave address map, arbiter state
// encoding and the slave word formatter).
package display_pkg;

    localparam int LEN      = 4;
    localparam int CHAR_LEN = 6;
    localparam int FRAME_W  = LEN * CHAR_LEN;

    localparam logic [4:0] DISP_ADDR_DIG0 = 5'd0;
    localparam logic [4:0] DISP_ADDR_DOT0 = 5'd4;
    localparam logic [4:0] DISP_ADDR_ENA  = 5'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } disp_state_e;

    // Slave word for write index idx: digit codes, then dot bits, then enable.
    function automatic logic [31:0] disp_word(input logic [3:0]         idx,
                                              input logic [FRAME_W-1:0] frame,
                                              input logic [LEN-1:0]     dots);
        logic [31:0] word;
        word = 32'd0;
        if ({1'b0, idx} < DISP_ADDR_DOT0) begin
            word[CHAR_LEN-1:0] = frame[int'(idx[1:0]) * CHAR_LEN +: CHAR_LEN];
        end else if ({1'b0, idx} < DISP_ADDR_ENA) begin
            word[0] = dots[idx[1:0]];
        end else begin
            word[0] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/display_rr_picker.sv
// display_rr_picker: combinational round-robin selector.
//   req   - request vector, one bit per requester
//   ptr   - requester with highest priority this round
//   valid - at least one request is pending
//   idx   - first requesting index found from ptr upwards, wrapping at N_REQ
module display_rr_picker #(
    parameter int N_REQ = 3,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester to ptr wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr} + (IW + 1)'(i);
            cand_s = (cand_s >= (IW + 1)'(N_REQ)) ? cand_s - (IW + 1)'(N_REQ) : cand_s;
            valid  = req[cand_s[IW-1:0]] ? 1'b1 : valid;
            idx    = req[cand_s[IW-1:0]] ? cand_s[IW-1:0] : idx;
        end
    end

endmodule

// File: rtl/display_req_arbiter.sv
// display_req_arbiter: shares the segment display among N_REQ requesters.
// A round-robin winner's frame is captured, written to the display slave as
// nine single-word Avalon-MM writes, then held for HOLD_CYCLES clocks.
//   clk, rst          - clock, synchronous active-high reset
//   req/req_data/dots - per-requester level request, frame codes, dot bits
//   grant             - one-cycle one-hot pulse when a frame is captured
//   busy, active_id   - not idle; last granted requester
//   m_*               - Avalon-MM write master towards the display slave
module display_req_arbiter
    import display_pkg::*;
#(
    parameter int          N_REQ       = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   req_data,
    input  logic [N_REQ*LEN-1:0]       req_dots,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic [2:0]                 active_id,
    output logic                       m_write,
    output logic [4:0]                 m_address,
    output logic [31:0]                m_writedata,
    input  logic                       m_waitrequest
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST_W = HW'(HOLD_LAST);

    disp_state_e          state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [3:0]           wr_idx_q, wr_idx_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [LEN-1:0]       dots_q, dots_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [2:0]           active_id_q, active_id_d;
    logic                 m_write_q, m_write_d;
    logic [4:0]           m_address_q, m_address_d;
    logic [31:0]          m_writedata_q, m_writedata_d;

    logic                 pick_valid_s;
    logic [IW-1:0]        pick_idx_s;
    logic [FRAME_W-1:0]   sel_frame_s;
    logic [LEN-1:0]       sel_dots_s;

    display_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign sel_frame_s = req_data[pick_idx_s * FRAME_W +: FRAME_W];
    assign sel_dots_s  = req_dots[pick_idx_s * LEN +: LEN];

    // Next-state and registered-output logic for capture, write burst and hold.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        wr_idx_d      = wr_idx_q;
        hold_cnt_d    = hold_cnt_q;
        frame_d       = frame_q;
        dots_d        = dots_q;
        grant_d       = '0;
        active_id_d   = active_id_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    // The first word is formatted straight from the inputs
                    // because the capture buffer loads on this same edge.
                    state_d       = WRITE;
                    frame_d       = sel_frame_s;
                    dots_d        = sel_dots_s;
                    grant_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    active_id_d   = 3'(pick_idx_s);
                    ptr_d         = (pick_idx_s == IW'(N_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
                    wr_idx_d      = 4'd0;
                    m_write_d     = 1'b1;
                    m_address_d   = DISP_ADDR_DIG0;
                    m_writedata_d = disp_word(4'd0, sel_frame_s, sel_dots_s);
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    if ({1'b0, wr_idx_q} == DISP_ADDR_ENA) begin
                        m_write_d     = 1'b0;
                        m_address_d   = 5'd0;
                        m_writedata_d = 32'd0;
                        hold_cnt_d    = '0;
                        state_d       = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                    end else begin
                        wr_idx_d      = wr_idx_q + 4'd1;
                        m_address_d   = {1'b0, wr_idx_d};
                        m_writedata_d = disp_word(wr_idx_d, frame_q, dots_q);
                    end
                end else begin
                    // Stalled: address and data stay as they are.
                    state_d = WRITE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST_W) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                m_write_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            wr_idx_q      <= 4'd0;
            hold_cnt_q    <= '0;
            frame_q       <= '0;
            dots_q        <= '0;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            active_id_q   <= 3'd0;
            m_write_q     <= 1'b0;
            m_address_q   <= 5'd0;
            m_writedata_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_idx_q      <= wr_idx_d;
            hold_cnt_q    <= hold_cnt_d;
            frame_q       <= frame_d;
            dots_q        <= dots_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            active_id_q   <= active_id_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign active_id   = active_id_q;
    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;

endmodule

// File: tb/tb_display_req_arbiter.sv
// Testbench for display_req_arbiter: directed stimulus with a write/grant
// scoreboard on the main instance (HOLD_CYCLES=4) and direct checks on a
// second instance with HOLD_CYCLES=0.
module tb_display_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [71:0] req_data = 72'd0;
    logic [11:0] req_dots = 12'd0;
    logic [2:0]  grant;
    logic        busy;
    logic [2:0]  active_id;
    logic        m_write;
    logic [4:0]  m_address;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    logic [2:0]  req_b = 3'b000;
    logic [71:0] req_data_b = 72'd0;
    logic [11:0] req_dots_b = 12'd0;
    logic [2:0]  grant_b;
    logic        busy_b;
    logic [2:0]  active_id_b;
    logic        m_write_b;
    logic [4:0]  m_address_b;
    logic [31:0] m_writedata_b;
    logic        m_waitrequest_b = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t        wq[$];
    logic [2:0] gq[$];

    display_req_arbiter #(.N_REQ(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dots(req_dots),
        .grant(grant), .busy(busy), .active_id(active_id), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
    );

    display_req_arbiter #(.N_REQ(3), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(req_data_b), .req_dots(req_dots_b),
        .grant(grant_b), .busy(busy_b), .active_id(active_id_b), .m_write(m_write_b),
        .m_address(m_address_b), .m_writedata(m_writedata_b), .m_waitrequest(m_waitrequest_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk_frame(input logic [5:0] d0, input logic [5:0] d1,
                                             input logic [5:0] d2, input logic [5:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic set_frame(input int k, input logic [23:0] fr, input logic [3:0] dt);
        req_data[k*24 +: 24] = fr;
        req_dots[k*4 +: 4]   = dt;
    endtask

    // Expected grant plus the first nw writes of frame fr/dt from requester k.
    task automatic push_frame(input int k, input logic [23:0] fr, input logic [3:0] dt, input int nw);
        wr_t e;
        gq.push_back(3'b001 << k);
        for (int a = 0; a < nw; a++) begin
            e.a = 5'(a);
            e.d = 32'd0;
            if (a < 4) e.d[5:0] = fr[a*6 +: 6];
            else if (a < 8) e.d[0] = dt[a-4];
            else e.d = 32'd1;
            wq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_drained(input string nm);
        check({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
        check({nm, "_grants_left"}, 32'(gq.size()), 32'd0);
    endtask

    // Scoreboard monitor: every completed write and every grant pulse is
    // matched against the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL write_extra: got addr %0d data 0x%0h want none", m_address, m_writedata);
            end else begin
                e = wq.pop_front();
                check("write_addr", {27'd0, m_address}, {27'd0, e.a});
                check("write_data", m_writedata, e.d);
            end
        end
        if (grant !== 3'b000 && grant !== 3'bxxx) begin
            if (gq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL grant_extra: got %b want none", grant);
            end else begin
                check("grant", {29'd0, grant}, {29'd0, gq.pop_front()});
            end
        end
    end

    initial begin
        logic [23:0] fr[3];
        logic [3:0]  dt[3];
        int t1_data[9] = '{1, 2, 3, 4, 1, 0, 1, 0, 1};
        wr_t e;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_active_id", {29'd0, active_id}, 32'd0);
        check("rst_m_write", {31'd0, m_write}, 32'd0);
        check("rst_m_address", {27'd0, m_address}, 32'd0);
        check("rst_m_writedata", m_writedata, 32'd0);

        // Single request, hand-computed writes, busy falls at cycle 14
        set_frame(0, mk_frame(6'd1, 6'd2, 6'd3, 6'd4), 4'b0101);
        req = 3'b001;
        gq.push_back(3'b001);
        for (int a = 0; a < 9; a++) begin
            e.a = 5'(a);
            e.d = 32'(t1_data[a]);
            wq.push_back(e);
        end
        tick();
        check("t1_grant_c1", {29'd0, grant}, 32'd1);
        req = 3'b000;
        repeat (12) tick();
        check("t1_busy_c13", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_c14", {31'd0, busy}, 32'd0);
        check_drained("t1");

        // Round robin with all three requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fr[k] = mk_frame(6'(10*k + 5), 6'(10*k + 6), 6'(10*k + 7), 6'(10*k + 8));
            set_frame(k, fr[k], 4'(4'b0011 << k));
            dt[k] = 4'(4'b0011 << k);
        end
        push_frame(0, fr[0], dt[0], 9);
        push_frame(1, fr[1], dt[1], 9);
        push_frame(2, fr[2], dt[2], 9);
        push_frame(0, fr[0], dt[0], 9);
        req = 3'b111;
        for (int r = 0; r < 4; r++) begin
            repeat ((r == 0) ? 1 : 14) tick();
            check("rr_grant_timing", {29'd0, grant}, {29'd0, 3'(3'b001 << (r % 3))});
        end
        req = 3'b000;
        wait_idle();
        check_drained("rr");

        // Stall of three cycles on address 2 (requester 1, pointer now 1)
        fr[1] = mk_frame(6'd7, 6'd8, 6'd9, 6'd10);
        set_frame(1, fr[1], 4'b1111);
        push_frame(1, fr[1], 4'b1111, 9);
        req = 3'b010;
        tick();
        req = 3'b000;
        tick();
        tick();
        m_waitrequest = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            check("stall_addr", {27'd0, m_address}, 32'd2);
            check("stall_data", m_writedata, 32'd9);
            if (c < 5) tick();
        end
        tick();
        m_waitrequest = 1'b0;
        repeat (6) tick();
        check("stall_c12_write", {26'd0, m_write, m_address}, {26'd0, 1'b1, 5'd8});
        tick();
        check("stall_c13_write", {31'd0, m_write}, 32'd0);
        wait_idle();
        check_drained("stall");

        // Frame altered after capture is not written (requester 2)
        fr[2] = mk_frame(6'd11, 6'd12, 6'd13, 6'd14);
        set_frame(2, fr[2], 4'b0110);
        push_frame(2, fr[2], 4'b0110, 9);
        req = 3'b100;
        tick();
        check("alter_active_id", {29'd0, active_id}, 32'd2);
        set_frame(2, 24'hFFFFFF, 4'b1001);
        req = 3'b000;
        wait_idle();
        check_drained("alter");

        // Request dropped before any sampling edge: no grant, stays idle
        req = 3'b001;
        #3;
        req = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("drop_busy", {31'd0, busy}, 32'd0);
        end
        check_drained("drop");

        // Reset at write index 5, then a new request restarts at address 0
        fr[0] = mk_frame(6'd21, 6'd22, 6'd23, 6'd24);
        set_frame(0, fr[0], 4'b1010);
        push_frame(0, fr[0], 4'b1010, 6);
        req = 3'b001;
        tick();
        req = 3'b000;
        repeat (5) tick();
        check("rstw_addr_c6", {27'd0, m_address}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_m_write", {31'd0, m_write}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_active_id", {29'd0, active_id}, 32'd0);
        check_drained("rstw_partial");
        fr[2] = mk_frame(6'd31, 6'd32, 6'd33, 6'd34);
        set_frame(2, fr[2], 4'b0001);
        push_frame(2, fr[2], 4'b0001, 9);
        req = 3'b100;
        tick();
        check("rstw_new_addr", {26'd0, m_write, m_address}, {26'd0, 1'b1, 5'd0});
        check("rstw_new_active_id", {29'd0, active_id}, 32'd2);
        req = 3'b000;
        wait_idle();
        check_drained("rstw_new");

        // HOLD_CYCLES=0 instance with req=011 held
        req_data_b[23:0] = mk_frame(6'd3, 6'd1, 6'd4, 6'd1);
        req_dots_b[3:0]  = 4'b1000;
        req_b = 3'b011;
        tick();
        check("h0_grant_c1", {29'd0, grant_b}, 32'd1);
        check("h0_data_c1", m_writedata_b, 32'd3);
        for (int c = 1; c <= 9; c++) begin
            check("h0_write", {26'd0, m_write_b, m_address_b}, {26'd0, 1'b1, 5'(c - 1)});
            tick();
        end
        check("h0_idle_c10", {29'd0, busy_b, m_write_b, |grant_b}, 32'd0);
        tick();
        check("h0_grant_c11", {29'd0, grant_b}, 32'd2);
        req_b = 3'b000;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_req_arbiter.md
# display_req_arbiter

Shares the four-digit segment display between several requesters. Each requester presents a full frame (four character codes plus four dot bits). The block picks one frame by round-robin and writes it into the display's Avalon-MM slave as a fixed burst of single-word writes. It then holds the frame on screen for a minimum time before serving the next request. The block sits between the application masters and the display slave, and is the only master on that slave.

## Interface

- N_REQ, 3: number of requesters, range 2–8.
- LEN, 4: digits per frame.
- CHAR_LEN, 6: width of one character code.
- HOLD_CYCLES, 50_000_000: minimum on-screen time in clk cycles after a frame is written. 0 is legal and disables the hold.

- clk  in  1: sole clock.
- rst  in  1: reset, synchronous, active-high.
- req  in  N_REQ: level request per requester; held high until its grant.
- req_data  in  N_REQ*LEN*CHAR_LEN: requester k's frame at [k*LEN*CHAR_LEN +: LEN*CHAR_LEN]; digit d at [d*CHAR_LEN +: CHAR_LEN].
- req_dots  in  N_REQ*LEN: requester k's dot bits at [k*LEN +: LEN].
- grant  out  N_REQ: one-hot, one-cycle pulse; marks the frame as captured.
- busy  out  1: high in any state other than IDLE.
- active_id  out  3: index of the last granted requester.
- m_write  out  1: Avalon write strobe.
- m_address  out  5: slave word address.
- m_writedata  out  32: write data.
- m_waitrequest  in  1: slave stall.

## Operation

- Slave address map:
  - 0..3: digit 0..3 code, zero-extended to 32 bits.
  - 4..7: dot 0..3, in bit 0.
  - 8: enable, data 1.
- States:
  - IDLE → WRITE when any req is high.
  - WRITE → HOLD after write index 8 completes, or → IDLE if HOLD_CYCLES=0.
  - HOLD → IDLE when the hold counter reaches HOLD_CYCLES-1.
- Arbitration: rotating pointer ptr.
  - Search order is ptr, ptr+1, … with wrap at N_REQ.
  - After granting k, ptr ← (k+1) mod N_REQ.
- On the IDLE→WRITE edge:
  - The selected requester's frame and dots are captured into an internal buffer.
  - grant[k]=1 for exactly the following cycle.
  - active_id ← k.
- WRITE: a 4-bit write index runs 0..8.
  - m_write=1 throughout.
  - m_address = index.
  - m_writedata is taken from the captured buffer.
  - A write completes in a cycle where m_write=1 and m_waitrequest=0; the index then advances.
  - While m_waitrequest=1, address and data are held stable.
- After capture, req and req_data changes are ignored until the next IDLE.
- A req dropped before its grant is simply not served; no state is kept for it.
- Requests arriving during WRITE or HOLD wait; they are served in round-robin order afterwards.

## Timing

- Reset values:
  - grant=0, busy=0, active_id=0, m_write=0, m_address=0, m_writedata=0.
  - ptr=0, state IDLE, counters 0.
- req sampled high at edge E0 → grant and the first write (address 0) in cycle 1 → with m_waitrequest=0, writes in cycles 1..9 → HOLD in cycles 10..9+HOLD_CYCLES → IDLE → next sample → next grant one cycle later.
- Each stall cycle on m_waitrequest adds exactly one cycle.
- Simultaneous requests: exactly one grant per frame; the pointer order decides.
- Reset mid-WRITE: m_write=0 from the next cycle. The partially written frame is left on the slave and is not rewritten.
- Reset mid-HOLD: returns to IDLE; a new request is then granted without waiting for the hold.
- The hold counter wraps only through the state transition; it never overflows.

## Structure

- Shared package display_pkg holds:
  - LEN and CHAR_LEN.
  - Address constants DISP_ADDR_DIG0=0, DISP_ADDR_DOT0=4, DISP_ADDR_ENA=8.
  - The state enum (IDLE, WRITE, HOLD).
- Sub-module display_rr_picker: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: valid, idx.
  - Reused by other display-sharing logic.

## Test plan

- Single request: req=001, frame digits {1,2,3,4}, dots 0101, HOLD_CYCLES=4, no stalls.
  - grant=001 in cycle 1.
  - Writes (addr,data): (0,1)(1,2)(2,3)(3,4)(4,1)(5,0)(6,1)(7,0)(8,1) in cycles 1–9.
  - busy falls at cycle 14.
- Round-robin with all three requesting continuously: grant order 001, 010, 100, 001; one frame per round.
- Stalls: m_waitrequest high for 3 cycles on address 2.
  - Address and data stay stable through the stall.
  - Write phase lasts 12 cycles.
  - No write is duplicated or skipped.
- Request changes after capture: req_data altered in the cycle after grant → written values still equal the captured frame. Request dropped before grant → no grant, stays IDLE.
- Reset at write index 5: m_write=0 next cycle; busy=0; ptr=0. A new req=100 is then granted with writes restarting at address 0.
- HOLD_CYCLES=0 with req=011 held: grant 001, 9 writes, then IDLE for 1 cycle, then grant 010.
